// File: rtl/multi_cycle_cpu_pkg.sv
// Shared types and constants for the multi-cycle MIPS-subset core: FSM states,
// opcode/funct encodings, ALU control encoding, trap causes and decode helpers.
package multi_cycle_cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRLV = 6'h06;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6
  } alu_ctrl_t;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd1;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

  // An R-type with an unsupported funct is treated as an illegal instruction.
  function automatic logic legal_insn(logic [5:0] op, logic [5:0] fn);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE: ok = fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_SRL, FN_SRLV};
      OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_LW, OP_SW: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic alu_ctrl_t funct_to_alu(logic [5:0] fn);
    alu_ctrl_t c;
    c = ALU_ADD;
    case (fn)
      FN_SUB:          c = ALU_SUB;
      FN_AND:          c = ALU_AND;
      FN_OR:           c = ALU_OR;
      FN_SLT:          c = ALU_SLT;
      FN_SLL:          c = ALU_SLL;
      FN_SRL, FN_SRLV: c = ALU_SRL;
      default:         c = ALU_ADD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multi_cycle_cpu_alu.sv
// Combinational ALU and shifter for the multi-cycle core; shifts operate on b
// by shamt, zero flags an all-zero result (used for branch compare).
module mcc_alu
  import multi_cycle_cpu_pkg::*;
(
  input  logic [2:0]  alu_ctrl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  output logic [31:0] y,
  output logic        zero
);

  always_comb begin
    y = '0;
    case (alu_ctrl_t'(alu_ctrl))
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {31'd0, $signed(a) < $signed(b)};
      ALU_SLL: y = b << shamt;
      ALU_SRL: y = b >> shamt;
      default: y = '0;
    endcase
  end

  assign zero = (y == 32'd0);

endmodule

// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core: one FSM sequences fetch/decode/exec/mem/wb over a
// unified ready-handshaked memory port. MULTI_CYCLE_CPU_PERF_EN adds perf counters.
module multi_cycle_cpu
  import multi_cycle_cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                MAX_WAIT = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_ready_i,
  output logic              trap_o,
  output logic [1:0]        trap_cause_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [2:0]        state_o
`ifdef MULTI_CYCLE_CPU_PERF_EN
  ,
  output logic [31:0]       perf_cycles_o,
  output logic [31:0]       perf_instret_o
`endif
);

  // Memory handshake: a transfer completes on a cycle where mem_req_o and
  // mem_ready_i are both high; request, address, we and wdata hold until then.
  state_t            state_q, state_d;
  logic [1:0]        cause_q, cause_d;
  logic [ADDR_W-1:0] pc_q, br_target, jump_target;
  logic [31:0]       ir_q, mdr_q, a_q, b_q, alu_out_q;
  logic [31:0]       rf [32];
  logic [7:0]        wait_q;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, wb_idx;
  logic [31:0] imm_sext, imm_zext, imm_sh, pc_ext, jump_full;
  logic        mem_active, wait_expire, is_branch, br_taken;

  alu_ctrl_t   alu_ctrl;
  logic [31:0] alu_b, alu_y;
  logic [4:0]  alu_shamt;
  logic        alu_zero;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign imm_zext = {16'd0, ir_q[15:0]};
  assign imm_sh   = {imm_sext[29:0], 2'b00};
  assign wb_idx   = (opcode == OP_RTYPE) ? rd : rt;

  assign br_target   = pc_q + imm_sh[ADDR_W-1:0];
  assign pc_ext      = 32'(pc_q);
  assign jump_full   = (pc_ext & 32'hF000_0000) | {4'b0000, ir_q[25:0], 2'b00};
  assign jump_target = jump_full[ADDR_W-1:0];

  assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign br_taken  = alu_zero ^ (opcode == OP_BNE);

  assign mem_active  = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign wait_expire = mem_active && !mem_ready_i && (wait_q == 8'(MAX_WAIT - 1));

  // Reset gates the request combinationally so an in-flight transfer aborts at once.
  assign mem_req_o    = mem_active && !rst_i;
  assign mem_we_o     = mem_req_o && (state_q == ST_MEM) && (opcode == OP_SW);
  assign mem_addr_o   = (state_q == ST_MEM) ? alu_out_q[ADDR_W-1:0] : pc_q;
  assign mem_wdata_o  = b_q;
  assign trap_o       = (state_q == ST_TRAP);
  assign trap_cause_o = cause_q;
  assign pc_o         = pc_q;
  assign state_o      = state_q;

  always_comb begin
    alu_ctrl  = ALU_ADD;
    alu_b     = b_q;
    alu_shamt = ir_q[10:6];
    case (opcode)
      OP_RTYPE: begin
        alu_ctrl = funct_to_alu(funct);
        if (funct == FN_SRLV) alu_shamt = a_q[4:0];
      end
      OP_ADDI, OP_LW, OP_SW: alu_b = imm_sext;
      OP_ORI: begin
        alu_ctrl = ALU_OR;
        alu_b    = imm_zext;
      end
      OP_BEQ, OP_BNE: alu_ctrl = ALU_SUB;
      default: alu_ctrl = ALU_ADD;
    endcase
  end

  mcc_alu u_alu (
    .alu_ctrl (alu_ctrl),
    .a        (a_q),
    .b        (alu_b),
    .shamt    (alu_shamt),
    .y        (alu_y),
    .zero     (alu_zero)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_FETCH;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready_i) begin
          state_d = ST_DECODE;
        end else if (wait_expire) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (legal_insn(opcode, funct)) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      ST_EXEC: begin
        case (opcode)
          OP_RTYPE, OP_ADDI, OP_ORI: state_d = ST_WB;
          OP_LW, OP_SW: begin
            if (alu_y[1:0] != 2'b00) begin
              state_d = ST_TRAP;
              cause_d = CAUSE_MISALIGN;
            end else begin
              state_d = ST_MEM;
            end
          end
          default: state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (mem_ready_i) begin
          state_d = (opcode == OP_LW) ? ST_WB : ST_FETCH;
        end else if (wait_expire) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_TRAP;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      mdr_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      wait_q    <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      if (mem_active && !mem_ready_i) wait_q <= wait_q + 8'd1;
      else                            wait_q <= '0;
      case (state_q)
        ST_FETCH: begin
          if (mem_ready_i) begin
            ir_q <= mem_rdata_i;
            pc_q <= pc_q + ADDR_W'(4);
          end
        end
        ST_DECODE: begin
          a_q       <= rf[rs];
          b_q       <= rf[rt];
          alu_out_q <= 32'(br_target);
        end
        ST_EXEC: begin
          alu_out_q <= alu_y;
          // Branch target was parked in alu_out_q during decode.
          if (is_branch && br_taken) pc_q <= alu_out_q[ADDR_W-1:0];
          if (opcode == OP_J)        pc_q <= jump_target;
        end
        ST_MEM: begin
          if (mem_ready_i && (opcode == OP_LW)) mdr_q <= mem_rdata_i;
        end
        ST_WB: begin
          if (wb_idx != 5'd0) rf[wb_idx] <= (opcode == OP_LW) ? mdr_q : alu_out_q;
        end
        default: ;
      endcase
    end
  end

`ifdef MULTI_CYCLE_CPU_PERF_EN
  logic instret;
  assign instret = (state_q == ST_WB)
                || ((state_q == ST_MEM) && (opcode == OP_SW) && mem_ready_i)
                || ((state_q == ST_EXEC) && (is_branch || (opcode == OP_J)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_cycles_o  <= '0;
      perf_instret_o <= '0;
    end else begin
      if ((state_q != ST_TRAP) && (perf_cycles_o != 32'hFFFF_FFFF))
        perf_cycles_o <= perf_cycles_o + 32'd1;
      if (instret && (perf_instret_o != 32'hFFFF_FFFF))
        perf_instret_o <= perf_instret_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Directed bench for multi_cycle_cpu: a behavioural memory with configurable
// wait-states, an expected-write queue, and hand-computed register/PC/trap checks.
module tb_multi_cycle_cpu;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ready_i;
  logic        trap_o;
  logic [1:0]  trap_cause_o;
  logic [31:0] pc_o;
  logic [2:0]  state_o;
`ifdef MULTI_CYCLE_CPU_PERF_EN
  logic [31:0] perf_cycles_o, perf_instret_o;
`endif

  int passed = 0;
  int total  = 0;

  logic [31:0] mem [128];
  logic [63:0] exp_q[$];
  int          wait_states    = 0;
  bit          hold_ready_low = 1'b0;
  int          data_reqs      = 0;
  int          we_cycles      = 0;
  int          last_wr_cycles = 0;
  bit          we_unstable    = 1'b0;
  logic [31:0] we_addr, we_data;

  multi_cycle_cpu #(.ADDR_W(32), .RESET_PC(32'h0), .MAX_WAIT(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ready_i  (mem_ready_i),
    .trap_o       (trap_o),
    .trap_cause_o (trap_cause_o),
    .pc_o         (pc_o),
    .state_o      (state_o)
`ifdef MULTI_CYCLE_CPU_PERF_EN
    ,
    .perf_cycles_o  (perf_cycles_o),
    .perf_instret_o (perf_instret_o)
`endif
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #2 rst_i = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    data_reqs      = 0;
    we_cycles      = 0;
    last_wr_cycles = 0;
    we_unstable    = 1'b0;
  endtask

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [4:0] sh, logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_j(logic [25:0] t);
    return {6'h02, t};
  endfunction

  // Memory responder and write scoreboard
  initial begin : mem_model
    int          waited;
    logic [63:0] exp_e;
    waited      = 0;
    mem_ready_i = 1'b0;
    mem_rdata_i = 32'h0;
    forever begin
      @(negedge clk_i);
      mem_ready_i = 1'b0;
      if (mem_req_o) begin
        if (mem_addr_o != pc_o) data_reqs++;
        if (mem_we_o) begin
          if (we_cycles == 0) begin
            we_addr = mem_addr_o;
            we_data = mem_wdata_o;
          end else if (mem_addr_o !== we_addr || mem_wdata_o !== we_data) begin
            we_unstable = 1'b1;
          end
          we_cycles++;
        end
        if (!hold_ready_low && waited >= wait_states) begin
          mem_ready_i = 1'b1;
          waited      = 0;
          if (mem_we_o) begin
            mem[mem_addr_o[8:2]] = mem_wdata_o;
            check("wr_queue_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
              exp_e = exp_q.pop_front();
              check("wr_addr", mem_addr_o, exp_e[63:32]);
              check("wr_data", mem_wdata_o, exp_e[31:0]);
            end
            last_wr_cycles = we_cycles;
            we_cycles      = 0;
          end else begin
            mem_rdata_i = mem[mem_addr_o[8:2]];
          end
        end else begin
          waited++;
        end
      end else begin
        waited = 0;
      end
    end
  end

  initial begin : stimulus
    // Reset state
    clear_mem();
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_req", {31'd0, mem_req_o}, 32'd0);
    check("rst_we", {31'd0, mem_we_o}, 32'd0);
    check("rst_trap", {31'd0, trap_o}, 32'd0);
    check("rst_cause", {30'd0, trap_cause_o}, 32'd0);
    check("rst_pc", pc_o, 32'h0);
    check("rst_state", {29'd0, state_o}, 32'd0);

    // Program 1: ALU coverage, zero wait-states
    clear_mem();
    wait_states = 0;
    mem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);        // addi $1,$0,5
    mem[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);     // addi $2,$0,-3
    mem[2]  = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);   // add  $3,$1,$2
    mem[3]  = enc_r(5'd2, 5'd1, 5'd4, 5'd0, 6'h2A);   // slt  $4,$2,$1
    mem[4]  = enc_i(6'h2B, 5'd0, 5'd3, 16'h0180);     // sw   $3,0x180
    mem[5]  = enc_i(6'h2B, 5'd0, 5'd4, 16'h0184);     // sw   $4,0x184
    mem[6]  = enc_r(5'd1, 5'd2, 5'd5, 5'd0, 6'h22);   // sub  $5,$1,$2
    mem[7]  = enc_r(5'd0, 5'd1, 5'd6, 5'd3, 6'h00);   // sll  $6,$1,3
    mem[8]  = enc_r(5'd0, 5'd2, 5'd7, 5'd28, 6'h02);  // srl  $7,$2,28
    mem[9]  = enc_r(5'd3, 5'd1, 5'd8, 5'd0, 6'h06);   // srlv $8,$1,$3
    mem[10] = enc_r(5'd1, 5'd2, 5'd9, 5'd0, 6'h24);   // and  $9,$1,$2
    mem[11] = enc_r(5'd1, 5'd2, 5'd10, 5'd0, 6'h25);  // or   $10,$1,$2
    mem[12] = enc_i(6'h0D, 5'd0, 5'd11, 16'h8001);    // ori  $11,$0,0x8001
    mem[13] = enc_i(6'h04, 5'd1, 5'd1, 16'd1);        // beq  $1,$1,+1
    mem[14] = enc_i(6'h08, 5'd0, 5'd12, 16'd7);       // addi $12,$0,7 (skipped)
    for (int i = 0; i < 8; i++)
      mem[15+i] = enc_i(6'h2B, 5'd0, 5'(5+i), 16'(16'h0188 + 4*i));
    mem[23] = enc_j(26'd23);
    exp_q.push_back({32'h180, 32'd2});
    exp_q.push_back({32'h184, 32'd1});
    exp_q.push_back({32'h188, 32'd8});
    exp_q.push_back({32'h18C, 32'h28});
    exp_q.push_back({32'h190, 32'hF});
    exp_q.push_back({32'h194, 32'd1});
    exp_q.push_back({32'h198, 32'd5});
    exp_q.push_back({32'h19C, 32'hFFFF_FFFD});
    exp_q.push_back({32'h1A0, 32'h8001});
    exp_q.push_back({32'h1A4, 32'd0});
    do_reset();
    run(16);
    check("p1_pc_16", pc_o, 32'd16);
    check("p1_state_16", {29'd0, state_o}, 32'd0);
`ifdef MULTI_CYCLE_CPU_PERF_EN
    check("p1_perf_instret", perf_instret_o, 32'd4);
    check("p1_perf_cycles", perf_cycles_o, 32'd16);
`endif
    run(84);
    check("p1_writes_done", 32'(exp_q.size()), 32'd0);
    check("p1_no_trap", {31'd0, trap_o}, 32'd0);
    exp_q.delete();

    // Program 2: sw then lw with two wait-states per access
    clear_mem();
    wait_states = 2;
    mem[0]  = enc_j(26'd8);                           // j 0x20
    mem[8]  = enc_i(6'h08, 5'd0, 5'd3, 16'd2);        // addi $3,$0,2
    mem[9]  = enc_i(6'h2B, 5'd0, 5'd3, 16'd8);        // sw   $3,8($0)
    mem[10] = enc_i(6'h23, 5'd0, 5'd5, 16'd8);        // lw   $5,8($0)
    mem[11] = enc_i(6'h2B, 5'd0, 5'd5, 16'h0180);     // sw   $5,0x180
    mem[12] = enc_j(26'd12);
    exp_q.push_back({32'h8, 32'd2});
    exp_q.push_back({32'h180, 32'd2});
    do_reset();
    run(36);
    check("p2_pc_36", pc_o, 32'h30);
    check("p2_state_36", {29'd0, state_o}, 32'd0);
    check("p2_wr_req_cycles", 32'(last_wr_cycles), 32'd3);
    check("p2_wr_stable", {31'd0, we_unstable}, 32'd0);
    check("p2_mem8", mem[2], 32'd2);
    check("p2_writes_done", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // Program 3: bne loop, five iterations counted in $2
    clear_mem();
    wait_states = 0;
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);         // addi $1,$0,5
    mem[1] = enc_i(6'h08, 5'd2, 5'd2, 16'd1);         // addi $2,$2,1
    mem[2] = enc_i(6'h08, 5'd1, 5'd1, 16'hFFFF);      // addi $1,$1,-1
    mem[3] = enc_i(6'h05, 5'd1, 5'd0, 16'hFFFD);      // bne  $1,$0,-3
    mem[4] = enc_i(6'h2B, 5'd0, 5'd2, 16'h0180);      // sw   $2,0x180
    mem[5] = enc_j(26'd5);
    exp_q.push_back({32'h180, 32'd5});
    do_reset();
    run(63);
    check("p3_pc_63", pc_o, 32'd20);
    check("p3_state_63", {29'd0, state_o}, 32'd0);
`ifdef MULTI_CYCLE_CPU_PERF_EN
    check("p3_perf_instret", perf_instret_o, 32'd17);
`endif
    run(10);
    check("p3_writes_done", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // Misaligned lw traps without a data request
    clear_mem();
    mem[0] = enc_i(6'h23, 5'd0, 5'd6, 16'd2);         // lw $6,2($0)
    do_reset();
    run(6);
    check("mis_trap", {31'd0, trap_o}, 32'd1);
    check("mis_cause", {30'd0, trap_cause_o}, 32'd2);
    check("mis_pc", pc_o, 32'd4);
    check("mis_no_data_req", 32'(data_reqs), 32'd0);
    check("mis_req_low", {31'd0, mem_req_o}, 32'd0);

    // Illegal opcode 0x3F
    clear_mem();
    mem[0] = 32'hFC00_0000;
    do_reset();
    run(4);
    check("ill_trap", {31'd0, trap_o}, 32'd1);
    check("ill_cause", {30'd0, trap_cause_o}, 32'd1);
    check("ill_pc", pc_o, 32'd4);

    // Bus timeout: ready never arrives, MAX_WAIT=4
    clear_mem();
    hold_ready_low = 1'b1;
    do_reset();
    run(3);
    check("to_no_trap_yet", {31'd0, trap_o}, 32'd0);
    check("to_req_held", {31'd0, mem_req_o}, 32'd1);
    run(1);
    check("to_trap", {31'd0, trap_o}, 32'd1);
    check("to_cause", {30'd0, trap_cause_o}, 32'd3);
    check("to_req_drop", {31'd0, mem_req_o}, 32'd0);
    #2 rst_i = 1'b1;
    #1;
    check("to_rst_trap_clr", {31'd0, trap_o}, 32'd0);
    check("to_rst_cause_clr", {30'd0, trap_cause_o}, 32'd0);
    hold_ready_low = 1'b0;

    // Reset pulsed mid-fetch after the PC has advanced
    clear_mem();
    wait_states = 2;
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd6);
    do_reset();
    run(13);
    check("mf_pc_before", pc_o, 32'd8);
    check("mf_req_before", {31'd0, mem_req_o}, 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check("mf_req_async_drop", {31'd0, mem_req_o}, 32'd0);
    check("mf_pc_reset", pc_o, 32'h0);
    check("mf_trap_clr", {31'd0, trap_o}, 32'd0);
    do_reset();
    run(6);
    check("mf_restart_pc", pc_o, 32'd4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
